// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the dcache AXI read path
`ifndef PADDR_SIZE
`define PADDR_SIZE 56
`endif
`ifndef XLEN
`define XLEN 64
`endif
`ifndef DCACHE_ID
`define DCACHE_ID 0
`endif
package dcache_pkg;
  localparam int ARB_N_REQ = 3;
  localparam int PADDR_W = `PADDR_SIZE;
  localparam int DCACHE_ID_BASE = `DCACHE_ID;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  typedef logic [$clog2(ARB_N_REQ)-1:0] arb_req_idx_t;
  typedef struct packed {
    logic [PADDR_W-1:0] addr;
    logic [7:0]         len;
    logic [2:0]         size;
  } ar_payload_t;
endpackage

// File: rtl/dcache_axi_read_arbiter_rr_picker.sv
// rr_picker: first eligible requester at or after the pointer, wrapping
module rr_picker #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  int j;
  // scan from the farthest offset down so the nearest eligible index wins
  always_comb begin
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (elig[j]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/dcache_axi_read_arbiter.sv
// dcache_axi_read_arbiter: round-robin sharing of one AXI AR/R channel among miss requesters
module dcache_axi_read_arbiter
  import dcache_pkg::*;
#(
  parameter int N_REQ      = ARB_N_REQ,
  parameter int ADDR_WIDTH = `PADDR_SIZE,
  parameter int DATA_WIDTH = `XLEN,
  parameter int ID_WIDTH   = 4,
  parameter int ID_BASE    = DCACHE_ID_BASE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_ar_valid,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0] req_ar_addr,
  input  logic [N_REQ-1:0][7:0]            req_ar_len,
  input  logic [N_REQ-1:0][2:0]            req_ar_size,
  output logic [N_REQ-1:0]                 req_ar_ready,
  output logic [N_REQ-1:0]                 req_r_valid,
  input  logic [N_REQ-1:0]                 req_r_ready,
  output logic [DATA_WIDTH-1:0]            req_r_data,
  output logic                             req_r_last,
  output logic [1:0]                       req_r_resp,
  output logic                             m_ar_valid,
  input  logic                             m_ar_ready,
  output logic [ID_WIDTH-1:0]              m_ar_id,
  output logic [ADDR_WIDTH-1:0]            m_ar_addr,
  output logic [7:0]                       m_ar_len,
  output logic [2:0]                       m_ar_size,
  output logic [1:0]                       m_ar_burst,
  input  logic                             m_r_valid,
  output logic                             m_r_ready,
  input  logic [ID_WIDTH-1:0]              m_r_id,
  input  logic [DATA_WIDTH-1:0]            m_r_data,
  input  logic                             m_r_last,
  input  logic [1:0]                       m_r_resp,
  output logic                             err_unexp_id
);
  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [N_REQ-1:0]    busy, gnt_oh, own_oh, clr;
  logic [IDXW-1:0]     rr_ptr, gnt_idx;
  logic                gnt_any, do_grant, hit, in_rng;
  logic [ID_WIDTH:0]   id_off;
  ar_payload_t         slot;
  rr_picker #(.N(N_REQ), .IW(IDXW)) u_pick (
    .elig(req_ar_valid & ~busy),
    .ptr (rr_ptr),
    .gnt (gnt_oh),
    .idx (gnt_idx),
    .any (gnt_any)
  );
  // grant when the AR slot is free or draining this cycle; decode R owner by ID
  always_comb begin
    do_grant     = rst && (!m_ar_valid || m_ar_ready) && gnt_any;
    req_ar_ready = do_grant ? gnt_oh : '0;
    id_off       = {1'b0, m_r_id} - (ID_WIDTH + 1)'(ID_BASE);
    in_rng       = !id_off[ID_WIDTH] && id_off < (ID_WIDTH + 1)'(N_REQ);
    own_oh       = in_rng ? N_REQ'(1) << id_off : '0;
    hit          = |(own_oh & busy);
    req_r_valid  = (rst && m_r_valid) ? own_oh & busy : '0;
    m_r_ready    = rst && (hit ? |(own_oh & req_r_ready) : 1'b1);
    clr          = (m_r_valid && m_r_ready && m_r_last && hit) ? own_oh : '0;
  end
  assign req_r_data = m_r_data;
  assign req_r_last = m_r_last;
  assign req_r_resp = m_r_resp;
  assign m_ar_addr  = ADDR_WIDTH'(slot.addr);
  assign m_ar_len   = slot.len;
  assign m_ar_size  = slot.size;
  assign m_ar_burst = AXI_BURST_INCR;
  // AR slot, busy tracking, round-robin pointer and sticky unexpected-ID flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ar_valid   <= 1'b0;
      m_ar_id      <= '0;
      slot         <= '0;
      busy         <= '0;
      rr_ptr       <= '0;
      err_unexp_id <= 1'b0;
    end else begin
      busy <= (busy & ~clr) | req_ar_ready;
      if (do_grant) begin
        m_ar_valid <= 1'b1;
        m_ar_id    <= ID_WIDTH'(ID_BASE) + ID_WIDTH'(gnt_idx);
        slot       <= '{addr: PADDR_W'(req_ar_addr[gnt_idx]), len: req_ar_len[gnt_idx], size: req_ar_size[gnt_idx]};
        rr_ptr     <= (gnt_idx == IDXW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (m_ar_ready) begin
        m_ar_valid <= 1'b0;
      end
      if (m_r_valid && !hit) err_unexp_id <= 1'b1;
    end
  end
endmodule
